spi_slave_tx_fifo: RTL and testbench
====================================

// Module: spi_slave_tx_fifo
// PURPOSE
//  Parametrised SPI-slave MISO transmitter. Runs entirely in the sys_clk domain and oversamples
//  external spi_sck/spi_cs_n. Words are pushed through a valid/ready port into an internal FIFO and
//  serialised back-to-back while CS is held low. Sits between the DAQ packetiser and the external
//  SPI master. Adds word width, buffering, SPI mode select and underrun handling.
// PARAMETERS
//  DATA_W     8    bits per SPI word (2..32)
//  FIFO_DEPTH 16   FIFO entries; power of 2, >=2
//  CPHA       0    0: mode 0 (bit 0 valid at CS fall, shift on sck fall); 1: mode 1 (shift on sck rise)
//  MSB_FIRST  1    1: MSB shifted first; 0: LSB first
//  IDLE_WORD  0    word transmitted when FIFO is empty at a word boundary (DATA_W bits)
// PORTS
//  sys_clk     in   1             system clock; must be >= 8x spi_sck
//  sys_rst     in   1             synchronous reset, active-high
//  s_data      in   DATA_W        word to transmit
//  s_valid     in   1             s_data valid
//  s_ready     out  1             FIFO can accept (= !full)
//  spi_sck     in   1             SPI clock, CPOL=0, asynchronous to sys_clk
//  spi_cs_n    in   1             chip select, active-low, asynchronous
//  spi_miso    out  1             serial data out
//  spi_miso_oe out  1             tri-state enable; 1 while synchronised CS is low
//  fifo_level  out  $clog2(FIFO_DEPTH)+1   current FIFO occupancy
//  word_done   out  1             1-cycle pulse when the last bit of a word has been shifted
//  underrun    out  1             1-cycle pulse when IDLE_WORD is loaded because the FIFO is empty
//  underrun_cnt out 16            saturating underrun count (only with SPI_TX_STATUS_EN)
// BEHAVIOUR
//  Reset: FIFO emptied, state IDLE, spi_miso=0, spi_miso_oe=0, word_done=0, underrun=0, fifo_level=0,
//   s_ready=1 from the first cycle after reset. Reset mid-frame aborts the word with no pulses.
//  Push: a word is written when s_valid&&s_ready at the sys_clk edge. s_ready is purely !full.
//   Push while full is ignored, even if a pop happens in the same cycle.
//  Sync: spi_sck and spi_cs_n each pass through a 2-flop synchroniser, then a registered edge detect.
//   spi_miso changes 3 sys_clk after the external edge.
//  FSM states: IDLE, LOAD, SHIFT.
//   IDLE: miso=0, oe=0. On CS fall go to LOAD.
//   LOAD (1 cycle): pop the FIFO head into the shift register. If the FIFO is empty, load IDLE_WORD
//    and pulse underrun. Pop and push in the same cycle on an empty FIFO is not bypassed: IDLE_WORD wins.
//    Drive the first bit, clear bit_cnt, go to SHIFT.
//   SHIFT: on each shift edge (sck fall if CPHA=0, sck rise if CPHA=1) drive the next bit and bit_cnt++.
//    CPHA=1: the first shift edge presents bit 0; bit_cnt counts from that edge.
//    When bit_cnt reaches DATA_W, pulse word_done and go to LOAD if CS is still low
//    (back-to-back words, no gap bit).
//  CS rise in any state: go to IDLE, miso=0, oe=0. A partially sent word is discarded (not re-sent).
//   A CS rise coinciding with the final shift edge still pulses word_done.
//  fifo_level increments on push, decrements on pop, unchanged on a simultaneous push+pop.
//   Pointers wrap modulo FIFO_DEPTH.
// CONFIGURATION
//  SPI_TX_STATUS_EN defined: underrun_cnt is present. It increments on each underrun pulse,
//   saturates at 16'hFFFF, and is cleared only by sys_rst.
//  SPI_TX_STATUS_EN undefined: the underrun_cnt port and its logic are absent. underrun is still present.
// STRUCTURE
//  spi_defs.vh (shared include): CPHA mode localparams SPI_MODE0/SPI_MODE1, FSM state encodings,
//   synchroniser stage count = 2.
//  Sub-module spi_tx_fifo: synchronous FWFT FIFO (DATA_W, FIFO_DEPTH) with full/empty/level.
//   The top holds the synchronisers, FSM, shift register and bit counter.
// TESTING
//  1 Push 8'hA5,8'h3C; CS low for 16 mode-0 clocks -> miso 1010_0101_0011_1100; 2 word_done pulses; level 2->0.
//  2 Empty FIFO, CS low, 8 clocks -> miso = IDLE_WORD bits, 1 underrun pulse, underrun_cnt=1 (macro on).
//  3 Push 17 words with DEPTH=16 -> s_ready=0 after 16; 17th not stored; level=16.
//  4 CS rises after 3 bits of 8'hF0 -> miso/oe drop within 3 cycles; next frame sends the next word, not F0.
//  5 CPHA=1, DATA_W=12, MSB_FIRST=0, word 12'h801 -> first bit 1 after first sck rise; last bit 1.
//  6 Assert sys_rst mid-word -> next cycle miso=0, oe=0, level=0, s_ready=1.

Source files
------------

// File: rtl/spi_slave_tx_fifo_pkg.sv
// Shared definitions for the SPI-slave MISO transmitter slice.
// Contents: SPI clock-phase mode constants, synchroniser depth and the
// transmit FSM state encoding. Imported by the FIFO and the top.
package spi_slave_tx_fifo_pkg;

  // Clock-phase modes (CPOL is always 0).
  localparam int SPI_MODE0 = 32'd0;  // bit 0 valid at CS fall, shift on sck fall
  localparam int SPI_MODE1 = 32'd1;  // bit 0 presented on first sck rise

  // Flops in each sck / cs_n synchroniser chain.
  localparam int SYNC_STAGES = 32'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/spi_slave_tx_fifo_if.sv
// Valid/ready word-push port of the SPI-slave transmitter.
// Signals:
//   s_data  - word to transmit (DATA_W bits)
//   s_valid - s_data valid
//   s_ready - transmitter FIFO can accept a word
// Modports: master (word producer), slave (transmitter).
interface spi_slave_tx_fifo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/spi_slave_tx_fifo_fifo.sv
// spi_tx_fifo: synchronous first-word-fall-through FIFO.
// Ports:
//   sys_clk, sys_rst       - clock, synchronous active-high reset
//   wr_data, wr_en         - push side; ignored while full
//   rd_en                  - pop request; ignored while empty
//   rd_data                - head word, valid whenever !empty
//   full, empty, level     - occupancy status
module spi_tx_fifo
  import spi_slave_tx_fifo_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic                        wr_en,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       level_r;
  logic              wr_ok_s;
  logic              rd_ok_s;

  assign full    = (level_r == (AW+1)'(FIFO_DEPTH));
  assign empty   = (level_r == '0);
  assign level   = level_r;
  assign rd_data = mem_r[rd_ptr_r];
  // A push while full is dropped even if a pop frees a slot this cycle.
  assign wr_ok_s = wr_en & ~full;
  assign rd_ok_s = rd_en & ~empty;

  // Storage array write port (contents need no reset).
  always_ff @(posedge sys_clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_tx_fifo.sv
// spi_slave_tx_fifo: SPI-slave MISO transmitter with an input FIFO.
// Oversamples spi_sck / spi_cs_n in the sys_clk domain and serialises FIFO
// words back-to-back while CS is low; IDLE_WORD is sent on FIFO underrun.
// Ports:
//   sys_clk, sys_rst           - clock, synchronous active-high reset
//   s_if (slave)               - valid/ready word push port
//   spi_sck, spi_cs_n          - asynchronous SPI master clock / select
//   spi_miso, spi_miso_oe      - serial data and its tri-state enable
//   fifo_level                 - FIFO occupancy
//   word_done, underrun        - single-cycle event pulses
//   underrun_cnt               - saturating underrun count, present only
//                                when SPI_TX_STATUS_EN is defined
module spi_slave_tx_fifo
  import spi_slave_tx_fifo_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 16,
  parameter int                CPHA       = 0,
  parameter int                MSB_FIRST  = 1,
  parameter logic [DATA_W-1:0] IDLE_WORD  = '0
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  spi_slave_tx_fifo_if.slave          s_if,
  input  logic                        spi_sck,
  input  logic                        spi_cs_n,
  output logic                        spi_miso,
  output logic                        spi_miso_oe,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        word_done,
  output logic                        underrun
`ifdef SPI_TX_STATUS_EN
  ,
  output logic [15:0]                 underrun_cnt
`endif
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

  // Bit presented first from a word, according to the shift order.
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) begin
      first_bit = w[DATA_W-1];
    end else begin
      first_bit = w[0];
    end
  endfunction

  // Word with the presented bit consumed.
  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
    if (MSB_FIRST != 0) begin
      shift_word = {w[DATA_W-2:0], 1'b0};
    end else begin
      shift_word = {1'b0, w[DATA_W-1:1]};
    end
  endfunction

  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic                   sck_d_r;
  logic                   cs_d_r;
  logic                   sck_rise_s;
  logic                   sck_fall_s;
  logic                   cs_rise_s;
  logic                   cs_fall_s;
  logic                   shift_edge_s;

  tx_state_e              state_r;
  logic [DATA_W-1:0]      shreg_r;
  logic [DATA_W-1:0]      next_word_s;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic                   miso_r;
  logic                   oe_r;
  logic                   word_done_r;
  logic                   underrun_r;

  logic                   fifo_rd_s;
  logic [DATA_W-1:0]      fifo_rd_data_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [DATA_W-1:0]      load_word_s;

  spi_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wr_data (s_if.s_data),
    .wr_en   (s_if.s_valid),
    .rd_en   (fifo_rd_s),
    .rd_data (fifo_rd_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (fifo_level)
  );

  assign s_if.s_ready = ~fifo_full_s;

  // Edge detect compares the last synchroniser stage with its delayed copy,
  // so an external edge reaches the FSM registers on the third sys_clk edge.
  assign sck_rise_s   = sck_sync_r[SYNC_STAGES-1] & ~sck_d_r;
  assign sck_fall_s   = ~sck_sync_r[SYNC_STAGES-1] & sck_d_r;
  assign cs_rise_s    = cs_sync_r[SYNC_STAGES-1] & ~cs_d_r;
  assign cs_fall_s    = ~cs_sync_r[SYNC_STAGES-1] & cs_d_r;
  assign shift_edge_s = (CPHA == SPI_MODE0) ? sck_fall_s : sck_rise_s;

  // A CS rise during LOAD aborts the frame without consuming the head word.
  assign fifo_rd_s    = (state_r == ST_LOAD) & ~cs_rise_s;
  // An empty FIFO always yields IDLE_WORD, even if a push lands this cycle.
  assign load_word_s  = fifo_empty_s ? IDLE_WORD : fifo_rd_data_s;
  assign next_word_s  = shift_word(shreg_r);

  // SPI clock and chip-select synchronisers plus edge-detect history.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sck_sync_r <= '0;
      cs_sync_r  <= '1;
      sck_d_r    <= 1'b0;
      cs_d_r     <= 1'b1;
    end else begin
      sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], spi_sck};
      cs_sync_r  <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
      sck_d_r    <= sck_sync_r[SYNC_STAGES-1];
      cs_d_r     <= cs_sync_r[SYNC_STAGES-1];
    end
  end

  // Transmit FSM, shift register, bit counter and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r     <= ST_IDLE;
      shreg_r     <= '0;
      bit_cnt_r   <= '0;
      miso_r      <= 1'b0;
      oe_r        <= 1'b0;
      word_done_r <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      word_done_r <= 1'b0;
      underrun_r  <= 1'b0;
      if (cs_rise_s) begin
        state_r <= ST_IDLE;
        miso_r  <= 1'b0;
        oe_r    <= 1'b0;
        // The final shift edge may coincide with deselect; the word counts.
        if ((state_r == ST_SHIFT) && shift_edge_s && (bit_cnt_r == LAST_CNT)) begin
          word_done_r <= 1'b1;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            miso_r <= 1'b0;
            oe_r   <= 1'b0;
            if (cs_fall_s) begin
              state_r <= ST_LOAD;
              oe_r    <= 1'b1;
            end
          end
          ST_LOAD: begin
            oe_r       <= 1'b1;
            shreg_r    <= load_word_s;
            bit_cnt_r  <= '0;
            underrun_r <= fifo_empty_s;
            state_r    <= ST_SHIFT;
            // Mode 1 keeps the previous bit on the line until the next sck rise.
            if (CPHA == SPI_MODE0) begin
              miso_r <= first_bit(load_word_s);
            end
          end
          ST_SHIFT: begin
            oe_r <= 1'b1;
            if (shift_edge_s) begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              if (CPHA == SPI_MODE0) begin
                // Mode 0: the last fall only ends the word; LOAD drives the next bit 0.
                if (bit_cnt_r != LAST_CNT) begin
                  shreg_r <= next_word_s;
                  miso_r  <= first_bit(next_word_s);
                end
              end else begin
                miso_r  <= first_bit(shreg_r);
                shreg_r <= next_word_s;
              end
              if (bit_cnt_r == LAST_CNT) begin
                word_done_r <= 1'b1;
                state_r     <= ST_LOAD;
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
            miso_r  <= 1'b0;
            oe_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign spi_miso    = miso_r;
  assign spi_miso_oe = oe_r;
  assign word_done   = word_done_r;
  assign underrun    = underrun_r;

`ifdef SPI_TX_STATUS_EN
  logic [15:0] underrun_cnt_r;

  // Saturating underrun counter, cleared only by reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      underrun_cnt_r <= 16'h0000;
    end else if (underrun_r && (underrun_cnt_r != 16'hFFFF)) begin
      underrun_cnt_r <= underrun_cnt_r + 16'h0001;
    end
  end

  assign underrun_cnt = underrun_cnt_r;
`endif

endmodule

// File: tb/tb_spi_slave_tx_fifo.sv
// Testbench for spi_slave_tx_fifo. dut0: mode 0, 8-bit, MSB first,
// IDLE_WORD 8'h5A. dut1: mode 1, 12-bit, LSB first. A word queue per DUT
// models the FIFO; received words are compared against its head.
module tb_spi_slave_tx_fifo;

  localparam logic [7:0] IDLE0 = 8'h5A;

  logic        clk;
  logic        sys_rst;
  logic        sck0, cs0_n, miso0, oe0, wd0, ur0;
  logic [4:0]  level0;
  logic        sck1, cs1_n, miso1, oe1, wd1, ur1;
  logic [4:0]  level1;
`ifdef SPI_TX_STATUS_EN
  logic [15:0] ucnt0;
  logic [15:0] ucnt1;
`endif

  int checks   = 0;
  int failures = 0;
  int wd0_cnt  = 0;
  int ur0_cnt  = 0;
  int wd1_cnt  = 0;
  int ur1_cnt  = 0;

  logic [7:0]  m0_q[$];
  logic [11:0] m1_q[$];

  spi_slave_tx_fifo_if #(.DATA_W(8))  if0 ();
  spi_slave_tx_fifo_if #(.DATA_W(12)) if1 ();

  spi_slave_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(16), .CPHA(0), .MSB_FIRST(1), .IDLE_WORD(IDLE0)) dut0 (
    .sys_clk(clk), .sys_rst(sys_rst), .s_if(if0), .spi_sck(sck0), .spi_cs_n(cs0_n),
    .spi_miso(miso0), .spi_miso_oe(oe0), .fifo_level(level0), .word_done(wd0), .underrun(ur0)
`ifdef SPI_TX_STATUS_EN
    , .underrun_cnt(ucnt0)
`endif
  );

  spi_slave_tx_fifo #(.DATA_W(12), .FIFO_DEPTH(16), .CPHA(1), .MSB_FIRST(0), .IDLE_WORD(12'h000)) dut1 (
    .sys_clk(clk), .sys_rst(sys_rst), .s_if(if1), .spi_sck(sck1), .spi_cs_n(cs1_n),
    .spi_miso(miso1), .spi_miso_oe(oe1), .fifo_level(level1), .word_done(wd1), .underrun(ur1)
`ifdef SPI_TX_STATUS_EN
    , .underrun_cnt(ucnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wd0) wd0_cnt <= wd0_cnt + 1;
    if (ur0) ur0_cnt <= ur0_cnt + 1;
    if (wd1) wd1_cnt <= wd1_cnt + 1;
    if (ur1) ur1_cnt <= ur1_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL timeout sim_time=%0t limit=1ms", $time);
    $fatal(1, "timeout");
  end

  task automatic push0(input logic [7:0] d);
    if0.s_data  = d;
    if0.s_valid = 1'b1;
    @(posedge clk);
    if (m0_q.size() < 16) m0_q.push_back(d);
    @(negedge clk);
    if0.s_valid = 1'b0;
  endtask

  task automatic push1(input logic [11:0] d);
    if1.s_data  = d;
    if1.s_valid = 1'b1;
    @(posedge clk);
    if (m1_q.size() < 16) m1_q.push_back(d);
    @(negedge clk);
    if1.s_valid = 1'b0;
  endtask

  // Mode-0 master: sample on rise, release CS together with the final fall when last.
  task automatic recv0(input bit last, output logic [7:0] w);
    logic b;
    w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(negedge clk);
      b = miso0;
      sck0 = 1'b1;
      repeat (8) @(negedge clk);
      sck0 = 1'b0;
      if (last && i == 7) cs0_n = 1'b1;
      w = {w[6:0], b};
    end
  endtask

  // Mode-1 master: sample during the high phase, LSB first.
  task automatic recv1(input bit chk_pre, output logic [11:0] w);
    w = 12'h000;
    for (int i = 0; i < 12; i++) begin
      repeat (8) @(negedge clk);
      if (chk_pre && i == 0) begin
        checks++;
        if (miso1 !== 1'b0) begin
          failures++;
          $display("FAIL cpha1_pre_rise got=%0b exp=%0b", miso1, 1'b0);
        end
      end
      sck1 = 1'b1;
      repeat (8) @(negedge clk);
      w[i] = miso1;
      sck1 = 1'b0;
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    cs0_n = 1'b1; sck0 = 1'b0; cs1_n = 1'b1; sck1 = 1'b0;
    if0.s_valid = 1'b0; if0.s_data = 8'h00;
    if1.s_valid = 1'b0; if1.s_data = 12'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sys_rst = 1'b0;
    m0_q.delete();
    m1_q.delete();
    @(negedge clk);
    checks++;
    if ({miso0, oe0, wd0, ur0} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", {miso0, oe0, wd0, ur0}, 4'b0000);
    end
    checks++;
    if (level0 !== 5'd0 || if0.s_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_fifo got=level %0d ready %0b exp=level 0 ready 1", level0, if0.s_ready);
    end
    checks++;
    if ({miso1, oe1, level1, if1.s_ready} !== {2'b00, 5'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_dut1 got=%b exp=%b", {miso1, oe1, level1, if1.s_ready}, {2'b00, 5'd0, 1'b1});
    end
`ifdef SPI_TX_STATUS_EN
    checks++;
    if (ucnt0 !== 16'd0) begin
      failures++;
      $display("FAIL reset_ucnt got=%0d exp=0", ucnt0);
    end
`endif
  endtask

  task automatic test_two_words();
    logic [7:0] w, e;
    int wb, ub;
    push0(8'hA5);
    push0(8'h3C);
    checks++;
    if (level0 !== 5'd2) begin
      failures++;
      $display("FAIL two_level_pre got=%0d exp=2", level0);
    end
    wb = wd0_cnt; ub = ur0_cnt;
    cs0_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      recv0(k == 1, w);
      e = (m0_q.size() > 0) ? m0_q.pop_front() : IDLE0;
      checks++;
      if (w !== e) begin
        failures++;
        $display("FAIL two_word%0d got=%h exp=%h", k, w, e);
      end
    end
    repeat (6) @(negedge clk);
    checks++;
    if (wd0_cnt - wb !== 2 || ur0_cnt - ub !== 0) begin
      failures++;
      $display("FAIL two_pulses got=wd %0d ur %0d exp=wd 2 ur 0", wd0_cnt - wb, ur0_cnt - ub);
    end
    checks++;
    if (level0 !== 5'd0 || oe0 !== 1'b0 || miso0 !== 1'b0) begin
      failures++;
      $display("FAIL two_post got=level %0d oe %0b miso %0b exp=0 0 0", level0, oe0, miso0);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] w;
    int wb, ub;
    wb = wd0_cnt; ub = ur0_cnt;
    cs0_n = 1'b0;
    recv0(1'b1, w);
    repeat (6) @(negedge clk);
    checks++;
    if (w !== IDLE0) begin
      failures++;
      $display("FAIL underrun_word got=%h exp=%h", w, IDLE0);
    end
    checks++;
    if (ur0_cnt - ub !== 1 || wd0_cnt - wb !== 1) begin
      failures++;
      $display("FAIL underrun_pulses got=ur %0d wd %0d exp=ur 1 wd 1", ur0_cnt - ub, wd0_cnt - wb);
    end
`ifdef SPI_TX_STATUS_EN
    checks++;
    if (ucnt0 !== 16'd1) begin
      failures++;
      $display("FAIL underrun_cnt got=%0d exp=1", ucnt0);
    end
`endif
  endtask

  task automatic test_full();
    logic [7:0] w, e;
    logic exp_rdy;
    int wb, ub;
    for (int i = 0; i < 17; i++) begin
      exp_rdy = (m0_q.size() < 16);
      checks++;
      if (if0.s_ready !== exp_rdy) begin
        failures++;
        $display("FAIL full_ready%0d got=%0b exp=%0b", i, if0.s_ready, exp_rdy);
      end
      push0(8'h10 + 8'(i));
    end
    checks++;
    if (level0 !== 5'd16 || if0.s_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_level got=level %0d ready %0b exp=level 16 ready 0", level0, if0.s_ready);
    end
    wb = wd0_cnt; ub = ur0_cnt;
    cs0_n = 1'b0;
    for (int k = 0; k < 16; k++) begin
      recv0(k == 15, w);
      e = (m0_q.size() > 0) ? m0_q.pop_front() : IDLE0;
      checks++;
      if (w !== e) begin
        failures++;
        $display("FAIL full_drain%0d got=%h exp=%h", k, w, e);
      end
    end
    repeat (6) @(negedge clk);
    checks++;
    if (level0 !== 5'd0 || wd0_cnt - wb !== 16 || ur0_cnt - ub !== 0) begin
      failures++;
      $display("FAIL full_post got=level %0d wd %0d ur %0d exp=0 16 0", level0, wd0_cnt - wb, ur0_cnt - ub);
    end
  endtask

  task automatic test_cs_abort();
    logic [7:0] w, e;
    int wb;
    push0(8'hF0);
    push0(8'h77);
    wb = wd0_cnt;
    cs0_n = 1'b0;
    e = m0_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      repeat (8) @(negedge clk);
      checks++;
      if (miso0 !== e[7-i]) begin
        failures++;
        $display("FAIL abort_bit%0d got=%0b exp=%0b", i, miso0, e[7-i]);
      end
      sck0 = 1'b1;
      repeat (8) @(negedge clk);
      sck0 = 1'b0;
    end
    repeat (4) @(negedge clk);
    cs0_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (miso0 !== 1'b0 || oe0 !== 1'b0) begin
      failures++;
      $display("FAIL abort_release got=miso %0b oe %0b exp=0 0", miso0, oe0);
    end
    checks++;
    if (wd0_cnt - wb !== 0 || level0 !== 5'd1) begin
      failures++;
      $display("FAIL abort_state got=wd %0d level %0d exp=wd 0 level 1", wd0_cnt - wb, level0);
    end
    repeat (8) @(negedge clk);
    cs0_n = 1'b0;
    recv0(1'b1, w);
    e = (m0_q.size() > 0) ? m0_q.pop_front() : IDLE0;
    checks++;
    if (w !== e) begin
      failures++;
      $display("FAIL abort_next got=%h exp=%h", w, e);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid_word();
    int wb;
    push0(8'hFF);
    push0(8'hFF);
    cs0_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      repeat (8) @(negedge clk);
      checks++;
      if (miso0 !== 1'b1) begin
        failures++;
        $display("FAIL rstmid_bit%0d got=%0b exp=1", i, miso0);
      end
      sck0 = 1'b1;
      repeat (8) @(negedge clk);
      sck0 = 1'b0;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (level0 !== 5'd1) begin
      failures++;
      $display("FAIL rstmid_level_pre got=%0d exp=1", level0);
    end
    wb = wd0_cnt;
    sys_rst = 1'b1;
    cs0_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m0_q.delete();
    checks++;
    if ({miso0, oe0, level0, if0.s_ready} !== {2'b00, 5'd0, 1'b1}) begin
      failures++;
      $display("FAIL rstmid_state got=%b exp=%b", {miso0, oe0, level0, if0.s_ready}, {2'b00, 5'd0, 1'b1});
    end
    repeat (2) @(negedge clk);
    sys_rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (wd0_cnt - wb !== 0 || oe0 !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_after got=wd %0d oe %0b exp=wd 0 oe 0", wd0_cnt - wb, oe0);
    end
  endtask

  task automatic test_cpha1();
    logic [11:0] w, e;
    int wb;
    push1(12'h801);
    push1(12'h5A3);
    wb = wd1_cnt;
    cs1_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      recv1(k == 0, w);
      e = (m1_q.size() > 0) ? m1_q.pop_front() : 12'h000;
      checks++;
      if (w !== e) begin
        failures++;
        $display("FAIL cpha1_word%0d got=%h exp=%h", k, w, e);
      end
      if (k == 0) begin
        checks++;
        if (w[0] !== 1'b1 || w[11] !== 1'b1) begin
          failures++;
          $display("FAIL cpha1_ends got=first %0b last %0b exp=1 1", w[0], w[11]);
        end
      end
    end
    repeat (4) @(negedge clk);
    cs1_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (wd1_cnt - wb !== 2 || level1 !== 5'd0 || oe1 !== 1'b0) begin
      failures++;
      $display("FAIL cpha1_post got=wd %0d level %0d oe %0b exp=2 0 0", wd1_cnt - wb, level1, oe1);
    end
  endtask

  initial begin
    sys_rst = 1'b1;
    test_reset();
    test_two_words();
    test_underrun();
    test_full();
    test_cs_abort();
    test_reset_mid_word();
    test_cpha1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
